// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of a single-ported memory with
// fixed read latency LAT (1-4 cycles after the issue cycle).
// Ties go round-robin by default; defining MEM_ARB_CPU_PRIO_EN makes ties
// always go to the CPU.
module mem_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        cpu_stall
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic            owner;       // 1 = DMA holds the current transaction
    logic            last_grant;  // 1 = DMA was granted last
    logic [CW-1:0]   cnt;
    logic            lat_we;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic            pick_dma;

    // Winner selection for the IDLE cycle
    always_comb begin
        pick_dma = 1'b0;
        if (d_req && !c_req) begin
            pick_dma = 1'b1;
        end else if (c_req && d_req) begin
`ifdef MEM_ARB_CPU_PRIO_EN
            pick_dma = 1'b0;
`else
            pick_dma = ~last_grant;
`endif
        end
    end

    // Memory address/data come straight from the request latch
    assign m_addr    = lat_addr;
    assign m_wdata   = lat_wdata;
    assign cpu_stall = c_req & ~c_ack;

    // Arbitration FSM with registered memory strobes, acks and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            m_en  <= 1'b0;
            m_we  <= 1'b0;
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_req || d_req) begin
                        owner      <= pick_dma;
                        last_grant <= pick_dma;
                        lat_we     <= pick_dma ? d_we    : c_we;
                        lat_addr   <= pick_dma ? d_addr  : c_addr;
                        lat_wdata  <= pick_dma ? d_wdata : c_wdata;
                        m_en       <= 1'b1;
                        m_we       <= pick_dma ? d_we    : c_we;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        c_ack <= ~owner;
                        d_ack <= owner;
                        state <= RESP;
                    end else begin
                        cnt   <= CW'(1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(LAT)) begin
                        if (owner) begin
                            d_rdata <= m_rdata;
                        end else begin
                            c_rdata <= m_rdata;
                        end
                        c_ack <= ~owner;
                        d_ack <= owner;
                        cnt   <= '0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=1 instance for the vector table and
// arbitration sequences, a LAT=4 instance for stall and mid-WAIT reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] m_rdata = '0;

    logic [31:0] c_rdata1, d_rdata1, m_addr1, m_wdata1;
    logic        c_ack1, d_ack1, m_en1, m_we1, cpu_stall1;
    logic [31:0] c_rdata4, d_rdata4, m_addr4, m_wdata4;
    logic        c_ack4, d_ack4, m_en4, m_we4, cpu_stall4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata1), .c_ack(c_ack1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata), .cpu_stall(cpu_stall1)
    );

    mem_arbiter #(.LAT(4)) dut4 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata4), .c_ack(c_ack4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata4), .d_ack(d_ack4),
        .m_en(m_en4), .m_we(m_we4), .m_addr(m_addr4), .m_wdata(m_wdata4),
        .m_rdata(m_rdata), .cpu_stall(cpu_stall4)
    );

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem;
        logic        drop;     // release req right after the grant edge
        logic        own;      // expected winner, 1 = DMA
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;      // ack sampled this many edges after grant
        logic [31:0] crd;
        logic [31:0] drd;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Issue one vector from IDLE on the LAT=1 instance and check it end to end
    task automatic run_vec(input int idx, input vec_t v);
        int k;
        int extra_en;
        logic both;
        logic got_d;
        c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        m_rdata = v.mem;
        tick();
        chk($sformatf("v%0d_issue", idx), {31'd0, m_en1, 31'd0, m_we1}, {31'd0, 1'b1, 31'd0, v.we});
        chk($sformatf("v%0d_maddr", idx), {m_addr1, m_wdata1}, {v.addr, v.wdata});
        if (v.drop) begin
            c_req = 1'b0;
            d_req = 1'b0;
        end
        k = 0; extra_en = 0; both = 1'b0; got_d = 1'b0;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            tick();
            if (m_en1) extra_en++;
            if (c_ack1 && d_ack1) both = 1'b1;
            if (c_ack1 || d_ack1) begin
                k = i;
                got_d = d_ack1;
            end
        end
        chk($sformatf("v%0d_ack_cycle", idx), 64'(k + 1), 64'(v.cyc));
        chk($sformatf("v%0d_ack_owner", idx), {63'd0, got_d}, {63'd0, v.own});
        chk($sformatf("v%0d_single_en_no_dual_ack", idx), 64'(extra_en) | {63'd0, both}, 64'd0);
        idle_inputs();
        tick();
        chk($sformatf("v%0d_rdata", idx), {c_rdata1, d_rdata1}, {v.crd, v.drd});
    endtask

    // Wait for a CPU ack on the LAT=4 instance; k = index of the edge after grant
    task automatic wait_ack4(output int k, output int stall_low);
        k = 0;
        stall_low = 0;
        for (int i = 1; i <= 12 && k == 0; i++) begin
            tick();
            if (c_ack4) k = i;
            else if (!cpu_stall4) stall_low++;
        end
    endtask

    initial begin
        int k;
        int stall_low;
        int n_ack;
        logic [3:0] order;
        logic [3:0] exp_order;
        logic dual;
        int ack_in_rst;

        vt[0] = '{1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0,
                  1'b0, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h12345678, 32'h0, 1'b1,
                  1'b1, 1'b1, 32'h100, 32'h12345678, 2, 32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'hA5A5A5A5, 1'b0,
                  1'b0, 1'b0, 32'h200, 32'h0, 3, 32'hA5A5A5A5, 32'h0};
`ifdef MEM_ARB_CPU_PRIO_EN
        vt[3] = '{1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b0, 32'h20, 32'h77, 32'h0BADF00D, 1'b0,
                  1'b0, 1'b1, 32'h10, 32'h1, 2, 32'hA5A5A5A5, 32'h0};
        vt[4] = '{1'b1, 1'b1, 32'h44, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                  1'b0, 1'b1, 32'h44, 32'hCAFEBABE, 2, 32'hA5A5A5A5, 32'h0};
        exp_order = 4'b0000;
`else
        vt[3] = '{1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b0, 32'h20, 32'h77, 32'h0BADF00D, 1'b0,
                  1'b1, 1'b0, 32'h20, 32'h77, 3, 32'hA5A5A5A5, 32'h0BADF00D};
        vt[4] = '{1'b1, 1'b1, 32'h44, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                  1'b0, 1'b1, 32'h44, 32'hCAFEBABE, 2, 32'hA5A5A5A5, 32'h0BADF00D};
        exp_order = 4'b1010;
`endif
        vt[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h11223344, 1'b0,
                  1'b1, 1'b0, 32'h80, 32'h0, 3, 32'hA5A5A5A5, 32'h11223344};
        vt[6] = '{1'b1, 1'b0, 32'h84, 32'h5, 1'b1, 1'b0, 32'h88, 32'h6, 32'h55667788, 1'b0,
                  1'b0, 1'b0, 32'h84, 32'h5, 3, 32'h55667788, 32'h11223344};

        // Reset values
        tick();
        tick();
        chk("rst_ctrl", {60'd0, m_en1, m_we1, c_ack1, d_ack1}, 64'd0);
        chk("rst_bus", {m_addr1, m_wdata1}, 64'd0);
        chk("rst_rdata", {c_rdata1, d_rdata1}, 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vt[i]);
        end

        // Both requesters held high across four reads
        do_reset();
        c_req = 1'b1; c_addr = 32'h300; d_req = 1'b1; d_addr = 32'h400;
        m_rdata = 32'h0000_5A5A;
        n_ack = 0; order = '0; dual = 1'b0;
        for (int i = 0; i < 40 && n_ack < 4; i++) begin
            tick();
            if (c_ack1 && d_ack1) dual = 1'b1;
            if (c_ack1 || d_ack1) begin
                order[n_ack] = d_ack1;
                n_ack++;
            end
        end
        idle_inputs();
        tick();
        chk("rr_ack_count", 64'(n_ack), 64'd4);
        chk("rr_ack_order", {60'd0, order}, {60'd0, exp_order});
        chk("rr_no_dual_ack", {63'd0, dual}, 64'd0);

        // LAT=4 CPU read: stall held until the ack cycle
        do_reset();
        c_req = 1'b1; c_addr = 32'h60; m_rdata = 32'h0F0F0F0F;
        #1;
        chk("lat4_stall_pre", {63'd0, cpu_stall4}, 64'd1);
        tick();
        chk("lat4_stall_issue", {63'd0, cpu_stall4}, 64'd1);
        wait_ack4(k, stall_low);
        chk("lat4_ack_cycle", 64'(k + 1), 64'd6);
        chk("lat4_stall_low_early", 64'(stall_low), 64'd0);
        chk("lat4_stall_ack", {63'd0, cpu_stall4}, 64'd0);
        idle_inputs();
        tick();
        chk("lat4_rdata", c_rdata4, 32'h0F0F0F0F);
        chk("lat4_stall_after", {63'd0, cpu_stall4}, 64'd0);

        // Reset asserted while the LAT=4 instance sits in WAIT
        c_req = 1'b1; c_addr = 32'h64; m_rdata = 32'h99999999;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_ctrl", {61'd0, c_ack4, m_en4, m_we4}, 64'd0);
        chk("midrst_data", {c_rdata4, m_addr4}, 64'd0);
        idle_inputs();
        ack_in_rst = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (c_ack4 || d_ack4) ack_in_rst++;
        end
        reset = 1'b1;
        tick();
        if (c_ack4 || d_ack4) ack_in_rst++;
        chk("midrst_no_ack", 64'(ack_in_rst), 64'd0);
        c_req = 1'b1; c_addr = 32'h68; m_rdata = 32'h13579BDF;
        tick();
        wait_ack4(k, stall_low);
        chk("postrst_ack_cycle", 64'(k + 1), 64'd6);
        idle_inputs();
        tick();
        chk("postrst_rdata", c_rdata4, 32'h13579BDF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
